// File: rtl/rll_pkg.sv
// Shared constants for the RLL(2,7) pair decoder: FSM states, pair encodings
// and the seven codeword -> data/length entries.
package rll_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_S00,
        ST_S01,
        ST_S10,
        ST_S0000,
        ST_S0001,
        ST_S0010,
        ST_S1001,
        ST_S000010,
        ST_S001001
    } rll_state_e;

    localparam logic [1:0] PAIR_00 = 2'b00;
    localparam logic [1:0] PAIR_01 = 2'b01;
    localparam logic [1:0] PAIR_10 = 2'b10;
    localparam logic [1:0] PAIR_11 = 2'b11;

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] len;
    } rll_word_t;

    // Data is right-aligned: the first decoded bit sits at data[len-1].
    localparam rll_word_t CW_0100     = '{data: 4'b0010, len: 3'd2};
    localparam rll_word_t CW_1000     = '{data: 4'b0011, len: 3'd2};
    localparam rll_word_t CW_100100   = '{data: 4'b0010, len: 3'd3};
    localparam rll_word_t CW_000100   = '{data: 4'b0000, len: 3'd3};
    localparam rll_word_t CW_001000   = '{data: 4'b0011, len: 3'd3};
    localparam rll_word_t CW_00100100 = '{data: 4'b0010, len: 3'd4};
    localparam rll_word_t CW_00001000 = '{data: 4'b0011, len: 3'd4};

endpackage

// File: rtl/rll_decoder.sv
// RLL(2,7) decoder: walks a pair tree, emits registered data/len or an error
// pulse one cycle after the final pair. RLL_ERR_CNT_EN adds a saturating error counter.
module rll_decoder
    import rll_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       valid_i,
    input  logic [1:0] code_i,
    output logic       valid_o,
    output logic [3:0] data_o,
    output logic [2:0] len_o,
    output logic       err_o
`ifdef RLL_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt_o
`endif
);

    rll_state_e state_q, state_d;
    logic       emit_d, err_d;
    rll_word_t  word_d;
    logic       valid_q, err_q;
    logic [3:0] data_q;
    logic [2:0] len_q;

    // Any accepted pair not matched below is an error and is discarded.
    always_comb begin
        state_d = state_q;
        emit_d  = 1'b0;
        err_d   = 1'b0;
        word_d  = '0;
        if (valid_i) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (code_i == PAIR_00) begin
                        state_d = ST_S00;  err_d = 1'b0;
                    end else if (code_i == PAIR_01) begin
                        state_d = ST_S01;  err_d = 1'b0;
                    end else if (code_i == PAIR_10) begin
                        state_d = ST_S10;  err_d = 1'b0;
                    end
                end
                ST_S00: begin
                    if (code_i == PAIR_00) begin
                        state_d = ST_S0000; err_d = 1'b0;
                    end else if (code_i == PAIR_01) begin
                        state_d = ST_S0001; err_d = 1'b0;
                    end else if (code_i == PAIR_10) begin
                        state_d = ST_S0010; err_d = 1'b0;
                    end
                end
                ST_S01: begin
                    if (code_i == PAIR_00) begin
                        emit_d = 1'b1; err_d = 1'b0; word_d = CW_0100;
                    end
                end
                ST_S10: begin
                    if (code_i == PAIR_00) begin
                        emit_d = 1'b1; err_d = 1'b0; word_d = CW_1000;
                    end else if (code_i == PAIR_01) begin
                        state_d = ST_S1001; err_d = 1'b0;
                    end
                end
                ST_S1001: begin
                    if (code_i == PAIR_00) begin
                        emit_d = 1'b1; err_d = 1'b0; word_d = CW_100100;
                    end
                end
                ST_S0000: begin
                    if (code_i == PAIR_10) begin
                        state_d = ST_S000010; err_d = 1'b0;
                    end
                end
                ST_S0001: begin
                    if (code_i == PAIR_00) begin
                        emit_d = 1'b1; err_d = 1'b0; word_d = CW_000100;
                    end
                end
                ST_S0010: begin
                    if (code_i == PAIR_00) begin
                        emit_d = 1'b1; err_d = 1'b0; word_d = CW_001000;
                    end else if (code_i == PAIR_01) begin
                        state_d = ST_S001001; err_d = 1'b0;
                    end
                end
                ST_S001001: begin
                    if (code_i == PAIR_00) begin
                        emit_d = 1'b1; err_d = 1'b0; word_d = CW_00100100;
                    end
                end
                ST_S000010: begin
                    if (code_i == PAIR_00) begin
                        emit_d = 1'b1; err_d = 1'b0; word_d = CW_00001000;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= emit_d;
            err_q   <= err_d;
            if (emit_d) begin
                data_q <= word_d.data;
                len_q  <= word_d.len;
            end
        end
    end

    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign data_o  = data_q;
    assign len_o   = len_q;

`ifdef RLL_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: doc/rll_decoder.md
RLL_DECODER -- requirements
Module: rll_decoder

Interface
REQ-001 The module SHALL have no parameters; all code constants come from rll_pkg.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 valid_i  input  1  code_i carries a valid code pair this cycle.
REQ-005 code_i  input  2  one RLL(2,7) channel pair; code_i[1] is the earlier channel bit.
REQ-006 valid_o  output  1  one-cycle pulse: data_o/len_o hold a decoded group.
REQ-007 data_o  output  4  decoded data bits, right-aligned; the first data bit is at data_o[len_o-1] and unused upper bits are 0.
REQ-008 len_o  output  3  number of valid data bits (2, 3 or 4).
REQ-009 err_o  output  1  one-cycle pulse: illegal pair sequence detected.
REQ-010 err_cnt_o  output  8  saturating error count; present only with RLL_ERR_CNT_EN.

Function
REQ-011 The decoder SHALL always accept input; a cycle with valid_i=0 SHALL leave the state and the partial word unchanged.
REQ-012 The FSM SHALL walk a pair tree with states IDLE, S00, S01, S10, S0000, S0001, S0010, S1001, S000010 and S001001.
REQ-013 From IDLE: 00->S00, 01->S01, 10->S10, 11->error.
REQ-014 From S01: 00 completes codeword 0100 and emits data "10" (len 2).
REQ-015 From S10: 00 completes codeword 1000 and emits "11" (len 2); 01->S1001.
REQ-016 From S1001: 00 completes codeword 100100 and emits "010" (len 3).
REQ-017 From S00: 00->S0000, 01->S0001, 10->S0010.
REQ-018 From S0001: 00 completes codeword 000100 and emits "000" (len 3).
REQ-019 From S0010: 00 completes codeword 001000 and emits "011" (len 3); 01->S001001.
REQ-020 From S001001: 00 completes codeword 00100100 and emits "0010" (len 4).
REQ-021 From S0000: 10->S000010.
REQ-022 From S000010: 00 completes codeword 00001000 and emits "0011" (len 4).
REQ-023 Any pair not listed in REQ-013..022 SHALL be an error: the FSM returns to IDLE and the offending pair is discarded, not re-parsed.
REQ-024 On completion the FSM SHALL return to IDLE, so back-to-back codewords decode with no idle cycle.
REQ-025 valid_o, data_o and len_o SHALL be registered and appear in the cycle after the edge that accepted the final pair; latency = 1 cycle.
REQ-026 data_o and len_o SHALL hold their last values while valid_o=0.
REQ-027 err_o SHALL follow the same 1-cycle latency as valid_o; valid_o and err_o are never high together.

Reset
REQ-028 Reset SHALL asynchronously force state=IDLE, valid_o=0, err_o=0, data_o=0, len_o=0 and err_cnt_o=0.
REQ-029 A partial codeword in flight at reset SHALL be dropped with no valid_o and no err_o.
REQ-030 Decoding SHALL resume correctly on the first valid pair after reset deasserts.

Configuration
REQ-031 With RLL_ERR_CNT_EN defined, err_cnt_o SHALL increment on every err_o event and saturate at 255.
REQ-032 Without RLL_ERR_CNT_EN, err_cnt_o and its counter logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 rll_pkg SHALL hold the FSM state enum, the seven codeword/data/length constants and the pair encodings.
REQ-034 No sub-module is required; the FSM and output registers SHALL live in rll_decoder.

Verification
REQ-035 Pairs 01,00 -> one cycle later valid_o=1, data_o=4'b0010, len_o=2.
REQ-036 Pairs 00,10,01,00 back-to-back with no idle cycle, then 10,00 -> two pulses: (4'b0010, len 4) and (4'b0011, len 2).
REQ-037 Pair 10 with valid_i=0 for 5 cycles, then pairs 01,00 -> no early output; then data_o=4'b0010, len_o=3.
REQ-038 Pair 11 in IDLE, then 00,00,10,00 -> err_o pulse, then data_o=4'b0011, len_o=4; with the macro, err_cnt_o=1.
REQ-039 Assert rst_i low after pairs 00,10 -> outputs zeroed; after release, 00,01,00 -> data_o=4'b0000, len_o=3.
REQ-040 With the macro, 300 consecutive 11 pairs -> err_cnt_o=255, held at 255.
